// File: rtl/serial_pkg.sv
// Shared types and constants for the FTDI serial link (serial_rx / serial_tx).
// Optional 8E1 framing is enabled by defining SERIAL_RX_PARITY_EN.
package serial_pkg;

    localparam int DEF_CLK_HZ = 12000000;
    localparam int DEF_BAUD   = 115200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // Even parity: the data bits and the parity bit together hold an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous input (RxD, RTS).
module serial_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // Reset to 1 so that leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/serial_rx.sv
// UART receiver for the FTDI RxD line: 8N1, LSB first, mid-bit sampling.
// Define SERIAL_RX_PARITY_EN to receive 8E1 frames with a parity check.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int BIT_TICKS  = CLK_HZ / BAUD,
    parameter int HALF_TICKS = BIT_TICKS / 2
) (
    input  logic       clk12,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rbyte,
    output logic       rbyte_rdy,
    output logic       framing_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TICK_W = $clog2(BIT_TICKS + 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    logic              rx_s;
    rx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rbyte_q, rbyte_d;
    logic              rdy_q, rdy_d;
    logic              ferr_q, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
`endif

    serial_rx_sync u_sync (
        .clk   (clk12),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + TICK_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        rbyte_d = rbyte_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick_q == HALF_LAST) begin
                    tick_d = '0;
                    bit_d  = 3'd0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q == BIT_LAST) begin
                    tick_d         = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (tick_q == BIT_LAST) begin
                    tick_d  = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
`endif
            // Stop is sampled mid-bit, so IDLE is re-entered half a bit early.
            STOP: begin
                if (tick_q == BIT_LAST) begin
                    tick_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else begin
                        state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (!even_parity_ok(shift_q, par_q)) begin
                            perr_d = 1'b1;
                        end else begin
                            rbyte_d = shift_q;
                            rdy_d   = 1'b1;
                        end
`else
                        rbyte_d = shift_q;
                        rdy_d   = 1'b1;
`endif
                    end
                end
            end
            BREAK: begin
                tick_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            rbyte_q <= 8'h00;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rbyte_q <= rbyte_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rbyte       = rbyte_q;
    assign rbyte_rdy   = rdy_q;
    assign framing_err = ferr_q;
    assign busy        = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- UART receiver; the receive-side counterpart of serial_tx on the FTDI link.
- Samples the FTDI RxD line (FTDI_BD0) in the clk12 domain.
- Delivers each received byte with a one-cycle ready strobe, mirroring serial_tx's sbyte/sbyte_rdy style.
- Frame format: 8N1, LSB first. The top level uses it for host-to-board commands and loopback echo.

Parameters:
- CLK_HZ, 12000000: clk12 frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- BIT_TICKS, CLK_HZ/BAUD (integer division, 104 at defaults): clocks per bit.
- HALF_TICKS, BIT_TICKS/2 (52 at defaults): clocks from the start edge to the start-bit centre.

Ports:
- clk12  input  1  sole clock, all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial input; idle is 1.
- rbyte  output  8  last good received byte; holds until the next good frame.
- rbyte_rdy  output  1  one-cycle pulse; rbyte is valid in the same cycle.
- framing_err  output  1  one-cycle pulse when the stop bit samples 0.
- parity_err  output  1  one-cycle parity failure pulse; tied 0 when the parity option is absent.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk12, rst_n). Sampled on posedge clk12; any rst_n=0 cycle aborts a frame in progress.
- Reset values: state=IDLE, synchronizer flops=1, bit counter=0, tick counter=0, rbyte=8'h00, rbyte_rdy=0, framing_err=0, parity_err=0, busy=0.
- Synchronizer: rx passes through two flops to give rx_s, so 2 cycles of input latency. All decisions use rx_s only.
- IDLE: when rx_s==0, go to START and clear the tick counter.
- START: count to HALF_TICKS-1.
  - rx_s==1 at that point: false start, return to IDLE with no pulse.
  - rx_s==0: go to DATA with bit index 0 and the tick counter cleared.
- DATA: each time the tick counter reaches BIT_TICKS-1, sample rx_s into shift-register bit [index] (LSB first) and clear the counter. After index 7 is sampled, go to STOP (or PARITY when the option is compiled in).
- STOP: sample at BIT_TICKS-1.
  - rx_s==1: load rbyte, pulse rbyte_rdy for exactly 1 cycle, go to IDLE.
  - rx_s==0: pulse framing_err, leave rbyte unchanged, go to BREAK.
- BREAK: wait for rx_s==1, then return to IDLE. A line held low therefore yields exactly one framing_err, not repeated frames.
- Latency: rbyte_rdy asserts 2 + HALF_TICKS + 9*BIT_TICKS cycles (plus 1 for the registered output) after the rx falling edge. With default parameters this is 991 cycles ±1.
- Back-to-back frames: IDLE is re-entered about half a bit before the stop bit ends, so a start bit immediately following the stop bit is caught with no gap required.
- Pulse exclusivity: rbyte_rdy, framing_err and parity_err are mutually exclusive in any cycle.
- Baud tolerance: ±2% total mismatch must be received correctly.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state follows DATA and samples one bit at BIT_TICKS-1.
  - The XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: parity_err pulses at stop-bit sample time, rbyte is not updated and rbyte_rdy stays low, then the stop-bit rules apply.
  - If the stop bit also fails, framing_err takes priority and parity_err stays low.
  - Latency grows by BIT_TICKS.
- Undefined: PARITY state and checker are absent; parity_err is constant 0.

Decomposition:
- Package serial_pkg:
  - rx state enum {IDLE, START, DATA, PARITY, STOP, BREAK}, 3-bit.
  - Shared constants DEF_CLK_HZ=12000000 and DEF_BAUD=115200, for reuse by serial_tx.
- One natural sub-module, serial_rx_sync: 2-flop synchronizer with reset-to-1, reusable for the FTDI RTS input.

Test Plan:
- Reset, then rx held 1 for 2000 cycles -> outputs at reset values, busy=0, no pulses.
- Send 0x48 ('H') at 115200 -> one rbyte_rdy pulse with rbyte=8'h48, 991±1 cycles after the start edge, framing_err=0.
- Send "Hello" back-to-back with zero idle between frames -> 5 rbyte_rdy pulses with 48,65,6C,6C,6F in order, none lost.
- Glitch: rx low for 20 cycles then high -> no pulse; busy returns to 0 within HALF_TICKS+3 cycles.
- Send 0x55 with stop bit forced 0, then rx held low for 3000 cycles, then released -> exactly one framing_err, rbyte keeps its previous value, next 0xA5 frame received correctly.
- Reset (rst_n=0 for 1 cycle) mid-DATA of 0x3C, then send 0x2A -> no pulse for the aborted frame; rbyte=8'h2A with a single rbyte_rdy. With SERIAL_RX_PARITY_EN defined: 0x2A with wrong parity -> parity_err pulse, no rbyte_rdy.
